// File: rtl/lowent_codebook_engine.sv
// Multi-codebook low-entropy matcher: one active prefix per code index, a run-time loaded
// codeword table, a valid/ready codeword stream and a sequential flush of pending prefixes.
module lowent_codebook_engine #(
  parameter int SYM_W       = 4,
  parameter int PREFIX_MAX  = 16,
  parameter int NUM_CODES   = 16,
  parameter int TABLE_DEPTH = 64,
  parameter int CW_MAX      = 21,
  localparam int CODE_W     = $clog2(NUM_CODES),
  localparam int ADDR_W     = $clog2(TABLE_DEPTH),
  localparam int PAT_W      = SYM_W * PREFIX_MAX,
  localparam int ENTRY_W    = 1 + 1 + CODE_W + 6 + PAT_W + 6 + CW_MAX
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               sym_valid_i,
  output logic               sym_ready_o,
  input  logic [SYM_W-1:0]   sym_i,
  input  logic [CODE_W-1:0]  sym_code_i,
  output logic               cw_valid_o,
  input  logic               cw_ready_i,
  output logic [CW_MAX-1:0]  cw_data_o,
  output logic [5:0]         cw_len_o,
  output logic               cw_flush_o,
  input  logic               flush_i,
  output logic               flush_done_o,
  output logic               busy_o,
  output logic               err_o,
  input  logic               cfg_we_i,
  input  logic [ADDR_W-1:0]  cfg_addr_i,
  input  logic [ENTRY_W-1:0] cfg_entry_i
);

  localparam int CWL_LSB  = CW_MAX;
  localparam int PAT_LSB  = CWL_LSB + 6;
  localparam int PL_LSB   = PAT_LSB + PAT_W;
  localparam int CODE_LSB = PL_LSB + 6;
  localparam int FL_BIT   = CODE_LSB + CODE_W;
  localparam int VL_BIT   = FL_BIT + 1;
  localparam logic [CODE_W-1:0] LAST_CODE = CODE_W'(NUM_CODES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   k_q, k_d;

  logic                t_valid [TABLE_DEPTH];
  logic                t_flush [TABLE_DEPTH];
  logic [CODE_W-1:0]   t_code  [TABLE_DEPTH];
  logic [5:0]          t_plen  [TABLE_DEPTH];
  logic [PAT_W-1:0]    t_pat   [TABLE_DEPTH];
  logic [5:0]          t_cwlen [TABLE_DEPTH];
  logic [CW_MAX-1:0]   t_cw    [TABLE_DEPTH];

  logic [5:0]          len_q [NUM_CODES];
  logic [PAT_W-1:0]    pat_q [NUM_CODES];

  logic                key_flush;
  logic [CODE_W-1:0]   key_code;
  logic [5:0]          key_plen;
  logic [PAT_W-1:0]    key_pat;
  logic                hit;
  logic [CW_MAX-1:0]   hit_cw;
  logic [5:0]          hit_cwlen;

  logic [5:0]          cand_plen;
  logic [PAT_W-1:0]    cand_pat;
  logic                slot_free, accept, advance;
  logic                pfx_wr, cw_load, err_d;
  logic [CODE_W-1:0]   pfx_idx;
  logic [5:0]          pfx_len;
  logic [PAT_W-1:0]    pfx_pat;

  logic                cw_valid_q, cw_flush_q, err_q;
  logic [CW_MAX-1:0]   cw_data_q;
  logic [5:0]          cw_len_q;

  assign slot_free   = !cw_valid_q || cw_ready_i;
  assign sym_ready_o = (state_q == IDLE) && slot_free;
  assign accept      = sym_valid_i && sym_ready_o;
  assign cand_plen   = len_q[sym_code_i] + 6'd1;
  assign cand_pat    = {pat_q[sym_code_i][PAT_W-SYM_W-1:0], sym_i};

  // One comparator serves both paths: symbol candidates in IDLE, flush lookups otherwise.
  always_comb begin
    key_flush = (state_q != IDLE);
    if (key_flush) begin
      key_code = k_q;
      key_plen = len_q[k_q];
      key_pat  = pat_q[k_q];
    end else begin
      key_code = sym_code_i;
      key_plen = cand_plen;
      key_pat  = cand_pat;
    end
  end

  always_comb begin
    hit       = 1'b0;
    hit_cw    = '0;
    hit_cwlen = '0;
    for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
      if (!hit && t_valid[i] && (t_flush[i] == key_flush) && (t_code[i] == key_code) &&
          (t_plen[i] == key_plen) && (t_pat[i] == key_pat)) begin
        hit       = 1'b1;
        hit_cw    = t_cw[i];
        hit_cwlen = t_cwlen[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    advance = 1'b0;
    pfx_wr  = 1'b0;
    pfx_idx = sym_code_i;
    pfx_len = '0;
    pfx_pat = '0;
    cw_load = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          pfx_wr = 1'b1;
          if (hit) begin
            cw_load = 1'b1;
          end else if (cand_plen == 6'(PREFIX_MAX)) begin
            err_d = 1'b1;
          end else begin
            pfx_len = cand_plen;
            pfx_pat = cand_pat;
          end
        end
        if (flush_i) begin
          state_d = SCAN;
          k_d     = '0;
        end
      end
      SCAN: begin
        pfx_idx = k_q;
        if (len_q[k_q] == '0) begin
          advance = 1'b1;
        end else if (!hit) begin
          pfx_wr  = 1'b1;
          err_d   = 1'b1;
          advance = 1'b1;
        end else if (slot_free) begin
          // A hit waits here until the previous codeword drains, keeping one outstanding.
          pfx_wr  = 1'b1;
          cw_load = 1'b1;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (cw_valid_q && cw_ready_i) advance = 1'b1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (k_q == LAST_CODE) begin
        state_d = DONE;
      end else begin
        state_d = SCAN;
        k_d     = k_q + CODE_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_CODES; i++) begin
        len_q[i] <= '0;
        pat_q[i] <= '0;
      end
    end else if (pfx_wr) begin
      len_q[pfx_idx] <= pfx_len;
      pat_q[pfx_idx] <= pfx_pat;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) t_valid[i] <= 1'b0;
    end else if (cfg_we_i) begin
      t_valid[cfg_addr_i] <= cfg_entry_i[VL_BIT];
    end
  end

  always_ff @(posedge clk_i) begin
    if (cfg_we_i) begin
      t_flush[cfg_addr_i] <= cfg_entry_i[FL_BIT];
      t_code[cfg_addr_i]  <= cfg_entry_i[CODE_LSB +: CODE_W];
      t_plen[cfg_addr_i]  <= cfg_entry_i[PL_LSB +: 6];
      t_pat[cfg_addr_i]   <= cfg_entry_i[PAT_LSB +: PAT_W];
      t_cwlen[cfg_addr_i] <= cfg_entry_i[CWL_LSB +: 6];
      t_cw[cfg_addr_i]    <= cfg_entry_i[0 +: CW_MAX];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cw_valid_q <= 1'b0;
      cw_flush_q <= 1'b0;
      cw_data_q  <= '0;
      cw_len_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (cw_load) begin
        cw_valid_q <= 1'b1;
        cw_flush_q <= key_flush;
        cw_data_q  <= hit_cw;
        cw_len_q   <= hit_cwlen;
      end else if (cw_ready_i) begin
        cw_valid_q <= 1'b0;
      end
    end
  end

  assign cw_valid_o   = cw_valid_q;
  assign cw_data_o    = cw_data_q;
  assign cw_len_o     = cw_len_q;
  assign cw_flush_o   = cw_flush_q;
  assign err_o        = err_q;
  assign busy_o       = (state_q != IDLE);
  assign flush_done_o = (state_q == DONE);

endmodule
